data_mem_responder: RTL and testbench

//  Responder end of the MEM-stage data-memory interface. Accepts one load/store

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 87 ++++++++
 tb/tb_data_mem_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage data-memory request/response bundle
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory responder with fixed latency
module data_mem_responder #(
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2,
  parameter int ADDR_LSB = 3
) (
  input logic                 CLK,
  input logic                 resetl,
  data_mem_responder_if.slave bus
);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH) << ADDR_LSB;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q;
  logic [63:0]      data_q;
  logic [63:0]      last_q;
  logic [63:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             req_err;
  logic             ready;
  logic             accept;

  assign idx     = bus.req_addr[ADDR_LSB +: IDX_W];
  assign req_err = (bus.req_addr[ADDR_LSB-1:0] != '0) || (bus.req_addr >= LIMIT);
  assign ready   = !resetl && (state_q == IDLE || state_q == RESP);
  assign accept  = bus.req_valid && ready;

  assign bus.req_ready  = ready;
  assign bus.resp_rdata = (state_q == RESP) ? data_q : last_q;
  assign bus.resp_err   = (state_q == RESP) && err_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        bus.busy = 1'b1;
        if (cnt_q == 4'd1) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // an accept in RESP overrides the return to IDLE, giving back-to-back service
    if (accept) begin
      if (LATENCY == 1) begin
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (resetl) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == RESP) last_q <= data_q;
      // load data is captured at accept so later stores cannot disturb it
      if (accept) begin
        err_q  <= req_err;
        data_q <= (bus.req_write || req_err) ? '0 : mem[idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept && bus.req_write && !req_err) mem[idx] <= bus.req_wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  logic        CLK = 1'b0;
  logic        resetl = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  int          sel = 0;

  always #5 CLK = ~CLK;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder_if bus2 ();

  data_mem_responder #(.LATENCY(2)) dut0 (.CLK(CLK), .resetl(resetl), .bus(bus0));
  data_mem_responder #(.LATENCY(1)) dut1 (.CLK(CLK), .resetl(resetl), .bus(bus1));
  data_mem_responder #(.LATENCY(4)) dut2 (.CLK(CLK), .resetl(resetl), .bus(bus2));

  assign bus0.req_valid = req_valid && (sel == 0);
  assign bus1.req_valid = req_valid && (sel == 1);
  assign bus2.req_valid = req_valid && (sel == 2);
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;

  logic        obs_ready, obs_valid, obs_err, obs_busy;
  logic [63:0] obs_rdata;
  assign obs_ready = (sel == 0) ? bus0.req_ready  : (sel == 1) ? bus1.req_ready  : bus2.req_ready;
  assign obs_valid = (sel == 0) ? bus0.resp_valid : (sel == 1) ? bus1.resp_valid : bus2.resp_valid;
  assign obs_err   = (sel == 0) ? bus0.resp_err   : (sel == 1) ? bus1.resp_err   : bus2.resp_err;
  assign obs_busy  = (sel == 0) ? bus0.busy       : (sel == 1) ? bus1.busy       : bus2.busy;
  assign obs_rdata = (sel == 0) ? bus0.resp_rdata : (sel == 1) ? bus1.resp_rdata : bus2.resp_rdata;

  // reference model: expected responses queued with the cycle they are due in
  typedef struct {
    int          due;
    logic [63:0] rdata;
    bit          known;
    bit          err;
  } resp_t;

  resp_t       pend[$];
  int          lat [3] = '{2, 1, 4};
  logic [63:0] mmem [3][256];
  bit          mknown [3][256];
  logic [63:0] last [3];
  bit          last_known [3];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          started = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (dut %0d, cycle %0d)", tag, got, exp, sel, cyc);
    end
  endtask

  initial begin
    bit    due_now, exp_ready, e;
    resp_t r;
    int    w;
    wait (started);
    forever begin
      @(negedge CLK);
      due_now   = (pend.size() != 0) && (pend[0].due == cyc);
      exp_ready = !resetl && ((pend.size() == 0) || due_now);
      check("req_ready", obs_ready, exp_ready);
      check("busy", obs_busy, (pend.size() != 0) && !due_now);
      check("resp_valid", obs_valid, due_now);
      if (due_now) begin
        r = pend.pop_front();
        check("resp_err", obs_err, r.err);
        if (r.known) check("resp_rdata", obs_rdata, r.rdata);
        last[sel]       = r.rdata;
        last_known[sel] = r.known;
      end else begin
        check("resp_err_idle", obs_err, 1'b0);
        if (last_known[sel]) check("resp_rdata_hold", obs_rdata, last[sel]);
      end
      if (req_valid && exp_ready) begin
        e     = (req_addr % 8 != 0) || (req_addr >= 64'd2048);
        r.due = cyc + lat[sel];
        r.err = e;
        if (e) begin
          r.rdata = '0;
          r.known = 1'b1;
        end else begin
          w = int'(req_addr / 8);
          if (req_write) begin
            mmem[sel][w]   = req_wdata;
            mknown[sel][w] = 1'b1;
            r.rdata        = '0;
            r.known        = 1'b1;
          end else begin
            r.rdata = mmem[sel][w];
            r.known = mknown[sel][w];
          end
        end
        pend.push_back(r);
      end
      if (resetl) begin
        pend.delete();
        for (int k = 0; k < 3; k++) begin
          last[k]       = '0;
          last_known[k] = 1'b1;
        end
      end
      cyc++;
    end
  end

  task automatic do_req(input bit wr, input logic [63:0] a, input logic [63:0] d);
    bit acc;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    acc       = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge CLK);
      acc = obs_ready;
      @(posedge CLK);
      #2;
    end
    check("handshake", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic pick(input int d);
    idle(6);
    sel = d;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int          r;
    resetl = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    started = 1'b1;
    @(posedge CLK);
    #2;
    resetl = 1'b0;

    // reset holds off a presented store
    pick(0);
    do_req(1'b1, 64'h20, 64'h1111);
    idle(3);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h2222;
    resetl = 1'b1;
    repeat (3) begin @(posedge CLK); #2; end
    resetl = 1'b0;
    idle(2);
    do_req(1'b0, 64'h20, '0);
    idle(4);

    do_req(1'b1, 64'h40, 64'hDEADBEEF_0000_0001);
    idle(3);
    do_req(1'b0, 64'h40, '0);
    idle(4);

    do_req(1'b1, 64'h0, 64'hA5A5_0000_1234_5678);
    do_req(1'b0, 64'h43, '0);
    do_req(1'b1, 64'h800, 64'hFFFF);
    do_req(1'b1, 64'h3, 64'hEEEE);
    do_req(1'b1, 64'h8000_0000_0000_0000, 64'hCCCC);
    do_req(1'b0, 64'h7F8, '0);
    do_req(1'b0, 64'h0, '0);
    idle(4);

    pick(1);
    for (int i = 0; i < 4; i++) do_req(1'b1, 64'(i * 8), 64'h100 + 64'(i));
    for (int i = 0; i < 4; i++) do_req(1'b0, 64'(i * 8), '0);
    idle(4);

    pick(0);
    do_req(1'b1, 64'h8, 64'h1234);
    idle(3);
    do_req(1'b0, 64'h8, '0);
    do_req(1'b1, 64'h8, 64'h5);
    do_req(1'b0, 64'h8, '0);
    idle(5);

    pick(2);
    do_req(1'b1, 64'h10, 64'h7);
    idle(1);
    resetl = 1'b1;
    @(posedge CLK);
    #2;
    resetl = 1'b0;
    idle(8);
    do_req(1'b0, 64'h10, '0);
    idle(6);

    for (int d = 0; d < 3; d++) begin
      pick(d);
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 9);
        if (r < 8)       a = 64'($urandom_range(0, 15)) * 8;
        else if (r == 8) a = 64'($urandom_range(0, 127)) * 8 + 64'($urandom_range(1, 7));
        else             a = {$urandom, $urandom} | 64'h800;
        do_req($urandom_range(0, 1) == 1, a, {$urandom, $urandom});
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 24) == 0) begin
          req_valid = 1'b0;
          resetl    = 1'b1;
          @(posedge CLK);
          #2;
          resetl = 1'b0;
        end
      end
      idle(8);
    end

    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
